// File: rtl/drrip_tag_lookup.sv
// drrip_tag_lookup: request/tag stage feeding the DRRIP replacement unit (hit pulse / held miss, victim fill, response); ports: clk, rst_n, req_* lookup in, resp_* response out, repl_* replacement unit link, flush; DRRIP_TAG_STATS_EN adds hit_count/miss_count
module drrip_tag_lookup #(
  parameter int NUM_WAYS        = 16,
  parameter int NUM_SETS        = 128,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int WAY_WIDTH       = 4,
  parameter int TAG_WIDTH       = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  input  logic [SET_INDEX_WIDTH-1:0] req_set,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_hit,
  output logic [WAY_WIDTH-1:0]       resp_way,
  output logic                       repl_valid,
  output logic [SET_INDEX_WIDTH-1:0] repl_set_index,
  output logic [WAY_WIDTH-1:0]       repl_access_way,
  output logic                       repl_hit,
  output logic                       repl_miss,
  input  logic [WAY_WIDTH-1:0]       repl_victim_way,
  input  logic                       repl_victim_ready,
  input  logic                       flush
`ifdef DRRIP_TAG_STATS_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
`endif
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_VICTIM, FILL, RESP} state_t;
  state_t state, state_nx;
  logic [TAG_WIDTH-1:0]       lat_tag;
  logic [SET_INDEX_WIDTH-1:0] lat_set;
  logic [WAY_WIDTH-1:0]       vic_way, hit_way, clamp_way, rsp_way;
  logic                       rsp_hit, hit;
  logic [NUM_WAYS-1:0]        vld [NUM_SETS];
  logic [TAG_WIDTH-1:0]       tags [NUM_SETS][NUM_WAYS];
  // Descending scan so the lowest matching way is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (vld[lat_set][i] && tags[lat_set][i] == lat_tag) begin
        hit = 1'b1;
        hit_way = WAY_WIDTH'(i);
      end
  end
  assign clamp_way = (32'(repl_victim_way) >= NUM_WAYS) ? WAY_WIDTH'(NUM_WAYS - 1) : repl_victim_way;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = flush ? IDLE : req_valid ? LOOKUP : IDLE;
      LOOKUP:      state_nx = hit ? RESP : WAIT_VICTIM;
      WAIT_VICTIM: state_nx = repl_victim_ready ? FILL : WAIT_VICTIM;
      FILL:        state_nx = RESP;
      RESP:        state_nx = resp_ready ? IDLE : RESP;
      default:     state_nx = IDLE;
    endcase
  end
  // rst_n gates req_ready so every output reads zero while reset is held.
  assign req_ready       = rst_n && state == IDLE && !flush;
  assign repl_hit        = state == LOOKUP && hit;
  // Miss drops in the victim-ready cycle so the unit does not restart its search.
  assign repl_miss       = state == WAIT_VICTIM && !repl_victim_ready;
  assign repl_valid      = repl_hit || repl_miss;
  assign repl_access_way = repl_hit ? hit_way : '0;
  assign repl_set_index  = (state == LOOKUP || state == WAIT_VICTIM || state == FILL) ? lat_set : '0;
  assign resp_valid      = state == RESP;
  assign resp_hit        = resp_valid && rsp_hit;
  assign resp_way        = resp_valid ? rsp_way : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lat_tag <= '0;
      lat_set <= '0;
      vic_way <= '0;
      rsp_hit <= 1'b0;
      rsp_way <= '0;
      for (int s = 0; s < NUM_SETS; s++) vld[s] <= '0;
    end else begin
      state <= state_nx;
      if (req_ready && req_valid) begin
        lat_tag <= req_tag;
        lat_set <= req_set;
      end
      if (state == IDLE && flush)
        for (int s = 0; s < NUM_SETS; s++) vld[s] <= '0;
      if (repl_hit) begin
        rsp_hit <= 1'b1;
        rsp_way <= hit_way;
      end
      if (state == WAIT_VICTIM && repl_victim_ready) vic_way <= clamp_way;
      if (state == FILL) begin
        vld[lat_set][vic_way] <= 1'b1;
        rsp_hit <= 1'b0;
        rsp_way <= vic_way;
      end
    end
  end
  always_ff @(posedge clk)
    if (state == FILL) tags[lat_set][vic_way] <= lat_tag;
`ifdef DRRIP_TAG_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (repl_hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (state == LOOKUP && !hit && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_drrip_tag_lookup.sv
// tb_drrip_tag_lookup: directed bench for drrip_tag_lookup with a transaction-level cache model
module tb_drrip_tag_lookup;
  localparam int NW = 16, NS = 128, SW = 7, WW = 4, TW = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, resp_ready = 1'b0, repl_victim_ready = 1'b0, flush = 1'b0;
  logic [TW-1:0] req_tag = '0;
  logic [SW-1:0] req_set = '0;
  logic [WW-1:0] repl_victim_way = '0;
  logic req_ready, resp_valid, resp_hit, repl_valid, repl_hit, repl_miss;
  logic [WW-1:0] resp_way, repl_access_way;
  logic [SW-1:0] repl_set_index;
`ifdef DRRIP_TAG_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  always #5 clk = ~clk;
  drrip_tag_lookup dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_set(req_set), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .repl_valid(repl_valid), .repl_set_index(repl_set_index),
    .repl_access_way(repl_access_way), .repl_hit(repl_hit), .repl_miss(repl_miss),
    .repl_victim_way(repl_victim_way), .repl_victim_ready(repl_victim_ready), .flush(flush)
`ifdef DRRIP_TAG_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  bit [NW-1:0] mv [NS];
  logic [TW-1:0] mt [NS][NW];
  int m_hits = 0, m_misses = 0;
  int vectors = 0, miscompares = 0;
  logic e_en = 1'b0, e_req_ready, e_resp_valid, e_resp_hit, e_repl_valid, e_hit, e_miss;
  logic [WW-1:0] e_resp_way, e_acc_way;
  logic [SW-1:0] e_set;
  logic g_hit;
  logic [WW-1:0] g_way;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  always @(negedge clk)
    if (e_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_req_ready));
      chk("resp_valid", 32'(resp_valid), 32'(e_resp_valid));
      chk("resp_hit", 32'(resp_hit), 32'(e_resp_hit));
      chk("resp_way", 32'(resp_way), 32'(e_resp_way));
      chk("repl_valid", 32'(repl_valid), 32'(e_repl_valid));
      chk("repl_hit", 32'(repl_hit), 32'(e_hit));
      chk("repl_miss", 32'(repl_miss), 32'(e_miss));
      chk("repl_access_way", 32'(repl_access_way), 32'(e_acc_way));
      chk("repl_set_index", 32'(repl_set_index), 32'(e_set));
    end
  task automatic exp_zero;
    e_req_ready = 0; e_resp_valid = 0; e_resp_hit = 0; e_resp_way = '0;
    e_repl_valid = 0; e_hit = 0; e_miss = 0; e_acc_way = '0; e_set = '0;
  endtask
  task automatic set_idle;
    req_valid = 0; flush = 0; resp_ready = 0; repl_victim_ready = 0;
    exp_zero;
    e_req_ready = 1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(string p);
    chk({p, "_req_ready"}, 32'(req_ready), 0);
    chk({p, "_resp_valid"}, 32'(resp_valid), 0);
    chk({p, "_resp_hit"}, 32'(resp_hit), 0);
    chk({p, "_resp_way"}, 32'(resp_way), 0);
    chk({p, "_repl_valid"}, 32'(repl_valid), 0);
    chk({p, "_repl_hit"}, 32'(repl_hit), 0);
    chk({p, "_repl_miss"}, 32'(repl_miss), 0);
    chk({p, "_repl_set"}, 32'(repl_set_index), 0);
    chk({p, "_repl_way"}, 32'(repl_access_way), 0);
  endtask
  task automatic chk_stats(string p);
`ifdef DRRIP_TAG_STATS_EN
    chk({p, "_hit_count"}, hit_count, 32'(m_hits));
    chk({p, "_miss_count"}, miss_count, 32'(m_misses));
`endif
  endtask
  // Model lookup: first valid way (lowest index) holding the tag.
  task automatic model_lookup(input logic [TW-1:0] t, input logic [SW-1:0] s, output bit h, output int w);
    h = 0; w = 0;
    for (int i = 0; i < NW; i++)
      if (!h && mv[s][i] && mt[s][i] == t) begin h = 1; w = i; end
  endtask
  // One full transaction: accept, lookup, optional victim wait/fill, response held for 'hold' cycles.
  task automatic do_req(input logic [TW-1:0] t, input logic [SW-1:0] s, input int dly,
                        input logic [WW-1:0] vw, input int hold, output logic gh, output logic [WW-1:0] gw);
    bit h;
    int w;
    step;
    req_valid = 1; req_tag = t; req_set = s; flush = 0; resp_ready = 0; repl_victim_ready = 0;
    exp_zero; e_req_ready = 1;
    step;
    req_valid = 0; req_tag = TW'($urandom); req_set = SW'($urandom);
    model_lookup(t, s, h, w);
    exp_zero; e_set = s; e_repl_valid = h; e_hit = h; e_acc_way = h ? WW'(w) : '0;
    if (h) m_hits++;
    else begin
      m_misses++;
      for (int i = 0; i < dly; i++) begin
        step; exp_zero; e_set = s; e_repl_valid = 1; e_miss = 1;
      end
      step; repl_victim_ready = 1; repl_victim_way = vw; exp_zero; e_set = s;
      step; repl_victim_ready = 0; repl_victim_way = WW'($urandom); exp_zero; e_set = s;
      w = (int'(vw) >= NW) ? NW - 1 : int'(vw);
      mv[s][w] = 1'b1;
      mt[s][w] = t;
    end
    for (int i = 0; i <= hold; i++) begin
      step; resp_ready = (i == hold); exp_zero;
      e_resp_valid = 1; e_resp_hit = h; e_resp_way = WW'(w);
    end
    gh = resp_hit; gw = resp_way;
    step; set_idle;
  endtask
  task automatic do_flush(input logic rv);
    step; flush = 1; req_valid = rv; req_tag = 20'h12345; req_set = 7'd5; exp_zero;
    foreach (mv[i]) mv[i] = '0;
    step; set_idle;
    step; set_idle;
  endtask
  initial begin
    #1 chk_zero("reset");
    @(posedge clk);
    step; rst_n = 1; set_idle; e_en = 1;
    step; chk_stats("post_reset");
    do_req(20'h12345, 7'd5, 4, 4'd3, 0, g_hit, g_way);
    chk("t1_hit", 32'(g_hit), 0); chk("t1_way", 32'(g_way), 3);
    do_req(20'h12345, 7'd5, 0, 4'd0, 0, g_hit, g_way);
    chk("t2_hit", 32'(g_hit), 1); chk("t2_way", 32'(g_way), 3);
    do_req(20'h12345, 7'd5, 0, 4'd0, 5, g_hit, g_way);
    chk("t3_hit", 32'(g_hit), 1); chk("t3_way", 32'(g_way), 3);
    do_req(20'hABCDE, 7'd5, 0, 4'd7, 1, g_hit, g_way);
    chk("t4_hit", 32'(g_hit), 0); chk("t4_way", 32'(g_way), 7);
    do_req(20'hABCDE, 7'd5, 0, 4'd0, 0, g_hit, g_way);
    chk("t5_hit", 32'(g_hit), 1); chk("t5_way", 32'(g_way), 7);
`ifdef DRRIP_TAG_STATS_EN
    chk("lit_hit_count", hit_count, 3); chk("lit_miss_count", miss_count, 2);
`endif
    chk_stats("after_5");
    do_flush(1'b0);
`ifdef DRRIP_TAG_STATS_EN
    chk("flush_hit_count", hit_count, 3); chk("flush_miss_count", miss_count, 2);
`endif
    do_req(20'h12345, 7'd5, 1, 4'd0, 0, g_hit, g_way);
    chk("t6_hit", 32'(g_hit), 0); chk("t6_way", 32'(g_way), 0);
    do_req(20'h12345, 7'd9, 2, 4'd15, 0, g_hit, g_way);
    chk("t7_way", 32'(g_way), 15);
    do_flush(1'b1);
    do_req(20'h0BEEF, 7'd20, 2, 4'd12, 0, g_hit, g_way);
    do_req(20'h0BEEF, 7'd20, 0, 4'd0, 0, g_hit, g_way);
    chk("t9_hit", 32'(g_hit), 1); chk("t9_way", 32'(g_way), 12);
    chk_stats("before_rst");
    step; req_valid = 1; req_tag = 20'h11111; req_set = 7'd20; exp_zero; e_req_ready = 1;
    step; req_valid = 0; exp_zero; e_set = 7'd20;
    step; exp_zero; e_set = 7'd20; e_repl_valid = 1; e_miss = 1;
    #2 rst_n = 0; e_en = 0;
    #1 chk_zero("async_rst");
    foreach (mv[i]) mv[i] = '0;
    m_hits = 0; m_misses = 0;
    step; step; rst_n = 1; set_idle; e_en = 1;
    for (int i = 0; i < 4; i++) step;
    chk_stats("after_rst");
    do_req(20'h0BEEF, 7'd20, 1, 4'd2, 0, g_hit, g_way);
    chk("t10_hit", 32'(g_hit), 0); chk("t10_way", 32'(g_way), 2);
    chk_stats("final");
    step; e_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
